pid_seq_ctrl: RTL
=================

Name: pid_seq_ctrl

Overview:
- Sequences the heading PID datapath. Each hdng_vld sample is saturated, then the P and D products are computed on one shared signed multiplier over successive cycles.
- Updates the integrator and emits a saturated pid_out with a one-cycle pid_vld.
- Sits between the heading-error source and the motor-mixing logic; owns prev_err history and integrator state.

Parameters:
- P_COEFF, 6'sh08, signed P gain
- D_COEFF, 5'sh0E, signed D gain
- I_SHIFT, 4, arithmetic right shift applied to integrator to form I_term

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- err  in  12  signed raw heading error, sampled when hdng_vld=1
- hdng_vld  in  1  new-sample strobe
- moving  in  1  0 = integrator cleared/held at 0
- pid_out  out  12  signed saturated PID result
- pid_vld  out  1  one-cycle pulse, pid_out updated
- busy  out  1  high whenever FSM not IDLE
- ovr  out  1  one-cycle pulse, pending sample overwritten

Behaviour:
- Reset values: pid_out=0, pid_vld=0, busy=0, ovr=0; prev_err=0, integ=0, pending=0, state=IDLE.
- err_sat: saturate err to 10 bits [-512,511]; captured into err_q on accept edge.
- FSM states: IDLE, MUL_P, MUL_D, ACCUM.
  - IDLE -> MUL_P on hdng_vld (err_q captured).
  - MUL_P -> MUL_D: p_prod <= mult.
  - MUL_D -> ACCUM: d_prod <= mult.
  - ACCUM -> MUL_P if pending (err_q <= pend_err, pending cleared), else IDLE.
- Latency: hdng_vld sampled at edge N -> pid_out/pid_vld registered at edge N+3; pid_vld high exactly one cycle.
- Shared multiplier: exactly one signed 6x10 multiplier, 16-bit product; operands muxed by state.
  - MUL_P: P_COEFF * err_q.
  - MUL_D: sext(D_COEFF) * sext(D_diff_sat).
- D_diff = err_q - prev_err (11 bits signed), saturated to 8 bits [-128,127].
- I_term = integ >>> I_SHIFT, using integ value BEFORE this sample's update.
- Sum in 17 bits signed: p_prod + d_prod + I_term; saturate to 12 bits [-2048,2047] -> pid_out.
- At edge leaving ACCUM:
  - prev_err <= err_q.
  - integ: if moving, integ <= sat16(integ + err_q); else integ <= 0.
- hdng_vld while busy: pend_err <= err_sat, pending <= 1. If pending already 1 and not consumed that edge, overwrite with newest sample and pulse ovr. Consume and new arrival on the same edge: new sample becomes pending, no ovr.
- hdng_vld in ACCUM with pending=0: sample goes to pending and starts next cycle; no IDLE bubble.
- rst_n asserted mid-operation: all state to reset values immediately; in-flight and pending samples discarded; no pid_vld.

Optional Feature:
- Macro PID_ANTIWINDUP_EN.
- Defined: integrator update skipped (integ held) on any sample whose 17-bit sum saturated pid_out.
- Undefined: integrator always updates (still sat16-limited and cleared when moving=0).

Test Plan:
- Reset, moving=1, err=12'd20, one hdng_vld -> pid_vld at edge+3, pid_out=440 (P 160 + D 280 + I 0); busy high 3 cycles.
- Repeat err=12'd20 -> pid_out=161 (P 160, D 0, I 20>>>4=1); integ=40.
- err=12'h7FF -> err_sat=511, pid_out=2047; then err=12'h800 -> err_sat=-512, pid_out=-2048.
- P_COEFF=0 build, err=12'd300 from reset -> D_diff 300 saturates to 127, pid_out=1778.
- hdng_vld at N and N+1 -> two pid_vld, at N+3 and N+6, ovr never pulses. hdng_vld at N, N+1, N+2 -> ovr pulse after edge N+2; second result uses the N+2 sample.
- rst_n low at N+2 mid-sequence -> no pid_vld, all outputs 0. moving=0 sample -> integ=0. With PID_ANTIWINDUP_EN, saturated sample leaves integ unchanged.

Source files
------------

// File: rtl/pid_seq_ctrl.sv
// rtl/pid_seq_ctrl.sv - heading PID sequencer on one shared signed multiplier.
// Optional macro PID_ANTIWINDUP_EN: hold the integrator on samples whose sum saturated pid_out.
module pid_seq_ctrl #(
  parameter logic signed [5:0] P_COEFF = 6'sh08,
  parameter logic signed [4:0] D_COEFF = 5'sh0E,
  parameter int                I_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] err,
  input  logic               hdng_vld,
  input  logic               moving,
  output logic signed [11:0] pid_out,
  output logic               pid_vld,
  output logic               busy,
  output logic               ovr
);

  typedef enum logic [1:0] {IDLE, MUL_P, MUL_D, ACCUM} state_t;

  state_t             state_q, state_d;
  logic signed [9:0]  err_q, err_d, pend_err_q, pend_err_d, prev_err_q, prev_err_d;
  logic               pending_q, pending_d;
  logic signed [15:0] p_prod_q, p_prod_d, d_prod_q, d_prod_d, integ_q, integ_d;
  logic signed [11:0] pid_out_q, pid_out_d;
  logic               pid_vld_q, pid_vld_d, ovr_q, ovr_d;

  logic signed [9:0]  err_sat;
  logic signed [10:0] d_diff;
  logic signed [7:0]  d_diff_sat;
  logic signed [5:0]  mult_a;
  logic signed [9:0]  mult_b;
  logic signed [15:0] mult;
  logic signed [15:0] i_term;
  logic signed [16:0] sum, integ_sum;
  logic signed [11:0] sum_sat;
  logic signed [15:0] integ_sat;

  always_comb begin
    if (err > 12'sd511)       err_sat = 10'sd511;
    else if (err < -12'sd512) err_sat = -10'sd512;
    else                      err_sat = err[9:0];

    d_diff = 11'(err_q) - 11'(prev_err_q);
    if (d_diff > 11'sd127)       d_diff_sat = 8'sd127;
    else if (d_diff < -11'sd128) d_diff_sat = -8'sd128;
    else                         d_diff_sat = d_diff[7:0];

    // Single multiplier: operands steered by state; sign extension is free in hardware.
    mult_a = (state_q == MUL_D) ? 6'(D_COEFF) : P_COEFF;
    mult_b = (state_q == MUL_D) ? 10'(d_diff_sat) : err_q;
    mult   = 16'(mult_a) * 16'(mult_b);

    i_term = integ_q >>> I_SHIFT;
    sum    = 17'(p_prod_q) + 17'(d_prod_q) + 17'(i_term);
    if (sum > 17'sd2047)       sum_sat = 12'sd2047;
    else if (sum < -17'sd2048) sum_sat = -12'sd2048;
    else                       sum_sat = sum[11:0];

    integ_sum = 17'(integ_q) + 17'(err_q);
    if (integ_sum > 17'sd32767)       integ_sat = 16'sh7FFF;
    else if (integ_sum < -17'sd32768) integ_sat = 16'sh8000;
    else                              integ_sat = integ_sum[15:0];
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    pend_err_d = pend_err_q;
    prev_err_d = prev_err_q;
    pending_d  = pending_q;
    p_prod_d   = p_prod_q;
    d_prod_d   = d_prod_q;
    integ_d    = integ_q;
    pid_out_d  = pid_out_q;
    pid_vld_d  = 1'b0;
    ovr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hdng_vld) begin
          err_d   = err_sat;
          state_d = MUL_P;
        end
      end
      MUL_P, MUL_D: begin
        if (state_q == MUL_P) begin
          p_prod_d = mult;
          state_d  = MUL_D;
        end else begin
          d_prod_d = mult;
          state_d  = ACCUM;
        end
        if (hdng_vld) begin
          pend_err_d = err_sat;
          pending_d  = 1'b1;
          ovr_d      = pending_q;
        end
      end
      ACCUM: begin
        pid_out_d  = sum_sat;
        pid_vld_d  = 1'b1;
        prev_err_d = err_q;
        if (!moving) integ_d = '0;
`ifdef PID_ANTIWINDUP_EN
        else if (sum == 17'(sum_sat)) integ_d = integ_sat;
`else
        else integ_d = integ_sat;
`endif
        // Pending sample is consumed here; a same-edge arrival simply refills the slot.
        if (pending_q) begin
          err_d      = pend_err_q;
          state_d    = MUL_P;
          pending_d  = hdng_vld;
          if (hdng_vld) pend_err_d = err_sat;
        end else if (hdng_vld) begin
          err_d   = err_sat;
          state_d = MUL_P;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      err_q      <= '0;
      pend_err_q <= '0;
      prev_err_q <= '0;
      pending_q  <= 1'b0;
      p_prod_q   <= '0;
      d_prod_q   <= '0;
      integ_q    <= '0;
      pid_out_q  <= '0;
      pid_vld_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      pend_err_q <= pend_err_d;
      prev_err_q <= prev_err_d;
      pending_q  <= pending_d;
      p_prod_q   <= p_prod_d;
      d_prod_q   <= d_prod_d;
      integ_q    <= integ_d;
      pid_out_q  <= pid_out_d;
      pid_vld_q  <= pid_vld_d;
      ovr_q      <= ovr_d;
    end
  end

  assign pid_out = pid_out_q;
  assign pid_vld = pid_vld_q;
  assign ovr     = ovr_q;
  assign busy    = (state_q != IDLE);

endmodule
